// File: rtl/countdown_pkg.sv
`default_nettype none
// ============================================================================
// Package     : countdown_pkg
// Description : Shared definitions for the countdown timer. Holds the FSM
//               state encoding, the seven-segment glyphs for 0-9 and blank,
//               and the digit-count to ceiling helper.
//               Glyph bit order is {dp,g,f,e,d,c,b,a}, active-high.
// Revision    : 1.0 - initial release
// ============================================================================
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    // Largest count a bank of 'digits' decimal tubes can show: 10^digits - 1.
    function automatic int max_count(input int digits);
        int v;
        v = 1;
        for (int i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/countdown_timer_ctrl_bcd_seg_digit.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seg_digit
// Description : Converts one BCD digit to a seven-segment byte. A set blank
//               flag, or a non-decimal code, yields an all-off byte.
// Ports       : digit_i [3:0] BCD digit
//               blank_i       force the tube dark
//               seg_o   [7:0] {dp,g,f,e,d,c,b,a}, active-high
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seg_digit
    import countdown_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [7:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/countdown_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : countdown_timer_ctrl
// Description : Loadable countdown timer with run/pause, warning window,
//               timed beep after expiry and a DIGITS-tube seven-segment
//               display of the remaining count (optional leading-zero
//               blanking).
// Ports       : clk, rst_n          clock, asynchronous active-low reset
//               clear               count <= DEFAULT_T, back to IDLE
//               load, load_val      count <= min(load_val, MAXV), IDLE
//               run_pause           level: 1 run, 0 pause
//               remaining           current count (binary)
//               busy                RUN or PAUSE
//               warn                RUN and 0 < count <= WARN_T
//               expired             one-cycle pulse when count reaches 0
//               beep                beeper enable, BEEP_TICKS ticks long
//               seg_out, seg_en     registered tube segments / enables
// Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_ctrl
    import countdown_pkg::*;
#(
    parameter int TICK_DIV   = 100_000_000,
    parameter int DIGITS     = 2,
    parameter int CNT_W      = 8,
    parameter int DEFAULT_T  = 10,
    parameter int WARN_T     = 3,
    parameter int BEEP_TICKS = 2,
    parameter int BLANK_LZ   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  load,
    input  logic [CNT_W-1:0]      load_val,
    input  logic                  run_pause,
    output logic [CNT_W-1:0]      remaining,
    output logic                  busy,
    output logic                  warn,
    output logic                  expired,
    output logic                  beep,
    output logic [8*DIGITS-1:0]   seg_out,
    output logic [DIGITS-1:0]     seg_en
);

    localparam int PRE_W  = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam int BEEP_W = (BEEP_TICKS < 1) ? 1 : $clog2(BEEP_TICKS + 1);

    localparam logic [CNT_W-1:0]  C_MAXV      = CNT_W'(max_count(DIGITS));
    localparam logic [CNT_W-1:0]  C_DEFAULT   = CNT_W'(DEFAULT_T);
    localparam logic [CNT_W-1:0]  C_WARN      = CNT_W'(WARN_T);
    localparam logic [CNT_W-1:0]  C_CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  C_CNT_ONE   = CNT_W'(1);
    localparam logic [PRE_W-1:0]  C_PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0]  C_PRE_ONE   = PRE_W'(1);
    localparam logic [BEEP_W-1:0] C_BEEP_LEN  = BEEP_W'(BEEP_TICKS);
    localparam logic [BEEP_W-1:0] C_BEEP_ONE  = BEEP_W'(1);
    localparam logic              C_BEEP_ON   = (BEEP_TICKS > 0);
    localparam logic              C_BLANK_LZ  = (BLANK_LZ != 0);

    state_e              state_q;
    logic [CNT_W-1:0]    count_q;
    logic [PRE_W-1:0]    presc_q;
    logic [BEEP_W-1:0]   beep_cnt_q;
    logic                beep_q;
    logic                expired_q;
    logic [8*DIGITS-1:0] seg_q;
    logic [DIGITS-1:0]   seg_en_q;

    logic [8*DIGITS-1:0] seg_d;
    logic [DIGITS-1:0]   seg_en_d;
    logic [4*DIGITS-1:0] bcd;
    logic [DIGITS-1:0]   blank;
    logic                nz_above;
    logic                presc_last;

    assign presc_last = (presc_q == C_PRE_LAST);

    // ------------------------------------------------------------------
    // FSM, counter, prescaler and beep timer. Branch order encodes the
    // same-cycle priority: clear, then load, then tick, then run_pause.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= C_DEFAULT;
            presc_q    <= '0;
            beep_cnt_q <= '0;
            beep_q     <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            expired_q <= 1'b0;
            if (clear) begin
                state_q    <= ST_IDLE;
                count_q    <= C_DEFAULT;
                presc_q    <= '0;
                beep_cnt_q <= '0;
                beep_q     <= 1'b0;
            end else if (load) begin
                state_q    <= ST_IDLE;
                count_q    <= (load_val > C_MAXV) ? C_MAXV : load_val;
                presc_q    <= '0;
                beep_cnt_q <= '0;
                beep_q     <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (run_pause && (count_q != C_CNT_ZERO)) begin
                            state_q <= ST_RUN;
                            presc_q <= '0;
                        end
                    end
                    ST_RUN: begin
                        if (presc_last) begin
                            // Tick outranks a pause request in the same cycle.
                            presc_q <= '0;
                            count_q <= count_q - C_CNT_ONE;
                            if (count_q == C_CNT_ONE) begin
                                state_q    <= ST_DONE;
                                expired_q  <= 1'b1;
                                beep_q     <= C_BEEP_ON;
                                beep_cnt_q <= C_BEEP_LEN;
                            end
                        end else begin
                            presc_q <= presc_q + C_PRE_ONE;
                            if (!run_pause) begin
                                state_q <= ST_PAUSE;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        // Prescaler held so the tick phase survives the pause.
                        if (run_pause) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_DONE: begin
                        // Prescaler only keeps running to time the beep.
                        if (beep_q) begin
                            if (presc_last) begin
                                presc_q    <= '0;
                                beep_cnt_q <= beep_cnt_q - C_BEEP_ONE;
                                if (beep_cnt_q == C_BEEP_ONE) begin
                                    beep_q <= 1'b0;
                                end
                            end else begin
                                presc_q <= presc_q + C_PRE_ONE;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Binary to BCD (double-dabble). Count is clamped to MAXV, so the
    // result always fits in DIGITS nibbles.
    // ------------------------------------------------------------------
    always_comb begin
        bcd = '0;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[4*DIGITS-2:0], count_q[i]};
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    // The units digit is never blanked.
    always_comb begin
        blank    = '0;
        nz_above = 1'b0;
        for (int d = DIGITS - 1; d >= 1; d--) begin
            nz_above = nz_above | (bcd[4*d +: 4] != 4'd0);
            blank[d] = C_BLANK_LZ & ~nz_above;
        end
    end

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_seg_digit u_digit (
                .digit_i (bcd[4*g +: 4]),
                .blank_i (blank[g]),
                .seg_o   (seg_d[8*g +: 8])
            );
        end
    endgenerate

    assign seg_en_d = ~blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q    <= '0;
            seg_en_q <= '0;
        end else begin
            seg_q    <= seg_d;
            seg_en_q <= seg_en_d;
        end
    end

    assign remaining = count_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign warn      = (state_q == ST_RUN) && (count_q != C_CNT_ZERO) &&
                       (count_q <= C_WARN);
    assign expired   = expired_q;
    assign beep      = beep_q;
    assign seg_out   = seg_q;
    assign seg_en    = seg_en_q;

endmodule
`default_nettype wire
